// File: rtl/led_seq_ctrl.sv
// Command-driven LED pattern sequencer: rotate right/left, flash, optional ping-pong (LED_SEQ_PINGPONG_EN).
// Latency: commands and ticks take effect on the next rising edge; o_rate visible the cycle after SET_RATE.
// Backpressure: o_cmd_ready drops only during the single LOAD cycle; the source must hold i_cmd_valid.
module led_seq_ctrl #(
    parameter int NB_LEDS = 4,
    parameter int NB_RATE = 2,
    parameter int NB_STEP = 8
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_cmd_valid,
    input  logic [2:0]         i_cmd,
    input  logic [NB_RATE-1:0] i_cmd_arg,
    output logic               o_cmd_ready,
    output logic               o_cnt_en,
    output logic [NB_RATE-1:0] o_rate,
    output logic [NB_LEDS-1:0] o_led,
    output logic [NB_STEP-1:0] o_step,
    output logic               o_cycle
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_PAUSE} state_t;
    typedef enum logic [1:0] {MD_SR, MD_SL, MD_FLASH, MD_PP} mode_t;

    localparam logic [2:0] OP_STOP      = 3'd0;
    localparam logic [2:0] OP_RUN_SR    = 3'd1;
    localparam logic [2:0] OP_RUN_SL    = 3'd2;
    localparam logic [2:0] OP_RUN_FLASH = 3'd3;
    localparam logic [2:0] OP_PAUSE     = 3'd4;
    localparam logic [2:0] OP_RESUME    = 3'd5;
    localparam logic [2:0] OP_SET_RATE  = 3'd6;
`ifdef LED_SEQ_PINGPONG_EN
    localparam logic [2:0] OP_RUN_PP    = 3'd7;
`endif

    localparam logic [NB_LEDS-1:0] SEED_MSB = {1'b1, {(NB_LEDS-1){1'b0}}};
    localparam logic [NB_LEDS-1:0] SEED_LSB = {{(NB_LEDS-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    mode_t                mode_q, mode_d;
    logic [NB_RATE-1:0]   rate_q, rate_d;
    logic [NB_LEDS-1:0]   led_q, led_d;
    logic [NB_STEP-1:0]   step_q, step_d;
    logic                 cycle_q, cycle_d;
`ifdef LED_SEQ_PINGPONG_EN
    logic                 dir_q, dir_d;   // 1 = moving toward MSB
    logic                 adv_dir;
`endif

    logic                 accept;
    logic                 run_cmd;
    mode_t                run_mode;
    logic [NB_LEDS-1:0]   adv_led;

    function automatic logic [NB_LEDS-1:0] seed_of(input mode_t m);
        logic [NB_LEDS-1:0] s;
        case (m)
            MD_SR:    s = SEED_MSB;
            MD_SL:    s = SEED_LSB;
            MD_FLASH: s = '1;
            default:  s = SEED_LSB;
        endcase
        return s;
    endfunction

    assign accept = i_cmd_valid && o_cmd_ready;

    always_comb begin
        run_cmd  = 1'b0;
        run_mode = MD_SR;
        case (i_cmd)
            OP_RUN_SR:    begin run_cmd = 1'b1; run_mode = MD_SR;    end
            OP_RUN_SL:    begin run_cmd = 1'b1; run_mode = MD_SL;    end
            OP_RUN_FLASH: begin run_cmd = 1'b1; run_mode = MD_FLASH; end
`ifdef LED_SEQ_PINGPONG_EN
            OP_RUN_PP:    begin run_cmd = 1'b1; run_mode = MD_PP;    end
`endif
            default: ;
        endcase
    end

    // Pattern the next tick would produce in the current mode.
    always_comb begin
        adv_led = led_q;
`ifdef LED_SEQ_PINGPONG_EN
        adv_dir = dir_q;
`endif
        case (mode_q)
            MD_SR:    adv_led = {led_q[0], led_q[NB_LEDS-1:1]};
            MD_SL:    adv_led = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
            MD_FLASH: adv_led = ~led_q;
`ifdef LED_SEQ_PINGPONG_EN
            MD_PP: begin
                if (dir_q) begin
                    adv_led = led_q << 1;
                    if (adv_led[NB_LEDS-1]) adv_dir = 1'b0;
                end else begin
                    adv_led = led_q >> 1;
                    if (adv_led[0]) adv_dir = 1'b1;
                end
            end
`endif
            default: adv_led = led_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rate_d  = rate_q;
        led_d   = led_q;
        step_d  = step_q;
        cycle_d = 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
        dir_d   = dir_q;
`endif
        if (accept && i_cmd == OP_SET_RATE) begin
            rate_d = i_cmd_arg;
        end

        case (state_q)
            ST_IDLE: begin
                led_d = '0;
                if (accept && run_cmd) begin
                    state_d = ST_LOAD;
                    mode_d  = run_mode;
                    led_d   = seed_of(run_mode);
                    step_d  = '0;
`ifdef LED_SEQ_PINGPONG_EN
                    dir_d   = 1'b1;
`endif
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Flow-changing commands take priority; a coincident tick is dropped.
                if (accept && run_cmd) begin
                    state_d = ST_LOAD;
                    mode_d  = run_mode;
                    led_d   = seed_of(run_mode);
                    step_d  = '0;
`ifdef LED_SEQ_PINGPONG_EN
                    dir_d   = 1'b1;
`endif
                end else if (accept && i_cmd == OP_STOP) begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                end else if (accept && i_cmd == OP_PAUSE) begin
                    state_d = ST_PAUSE;
                end else if (i_tick) begin
                    led_d   = adv_led;
                    step_d  = step_q + NB_STEP'(1);
                    cycle_d = (adv_led == seed_of(mode_q));
`ifdef LED_SEQ_PINGPONG_EN
                    dir_d   = adv_dir;
`endif
                end
            end
            ST_PAUSE: begin
                if (accept && i_cmd == OP_RESUME) begin
                    state_d = ST_RUN;
                end else if (accept && i_cmd == OP_STOP) begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MD_SR;
            rate_q  <= '0;
            led_q   <= '0;
            step_q  <= '0;
            cycle_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rate_q  <= rate_d;
            led_q   <= led_d;
            step_q  <= step_d;
            cycle_q <= cycle_d;
        end
    end

`ifdef LED_SEQ_PINGPONG_EN
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            dir_q <= 1'b1;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign o_cmd_ready = (state_q != ST_LOAD);
    assign o_cnt_en    = (state_q == ST_RUN);
    assign o_rate      = rate_q;
    assign o_led       = led_q;
    assign o_step      = step_q;
    assign o_cycle     = cycle_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed table-driven bench for led_seq_ctrl (NB_LEDS=4, NB_RATE=2, NB_STEP=8).
module tb_led_seq_ctrl;

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic       i_cmd_valid;
    logic [2:0] i_cmd;
    logic [1:0] i_cmd_arg;
    logic       o_cmd_ready;
    logic       o_cnt_en;
    logic [1:0] o_rate;
    logic [3:0] o_led;
    logic [7:0] o_step;
    logic       o_cycle;

    int n_cmp = 0;
    int n_bad = 0;

    led_seq_ctrl #(.NB_LEDS(4), .NB_RATE(2), .NB_STEP(8)) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_tick      (i_tick),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd       (i_cmd),
        .i_cmd_arg   (i_cmd_arg),
        .o_cmd_ready (o_cmd_ready),
        .o_cnt_en    (o_cnt_en),
        .o_rate      (o_rate),
        .o_led       (o_led),
        .o_step      (o_step),
        .o_cycle     (o_cycle)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       vld;
        logic [2:0] cmd;
        logic [1:0] arg;
        logic       tick;
        logic [3:0] led;
        int         step;   // -1: not checked
        logic       cyc;
        logic       en;
        logic       rdy;
        logic [1:0] rate;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic [2:0] cmd, input logic [1:0] arg,
                                input logic tick, input logic [3:0] led, input int step,
                                input logic cyc, input logic en, input logic rdy,
                                input logic [1:0] rate);
        vec_t v;
        v.vld = vld; v.cmd = cmd; v.arg = arg; v.tick = tick;
        v.led = led; v.step = step; v.cyc = cyc; v.en = en; v.rdy = rdy; v.rate = rate;
        return v;
    endfunction

    task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL v%0d %s: got %0h want %0h", idx, nm, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        chk(idx, "led",   32'(o_led),       32'(v.led));
        if (v.step >= 0) chk(idx, "step", 32'(o_step), v.step);
        chk(idx, "cycle", 32'(o_cycle),     32'(v.cyc));
        chk(idx, "cnt_en",32'(o_cnt_en),    32'(v.en));
        chk(idx, "ready", 32'(o_cmd_ready), 32'(v.rdy));
        chk(idx, "rate",  32'(o_rate),      32'(v.rate));
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clock);
        i_cmd_valid = v.vld;
        i_cmd       = v.cmd;
        i_cmd_arg   = v.arg;
        i_tick      = v.tick;
        @(posedge clock);
        #1;
        check_all(idx, v);
    endtask

    vec_t tbl[$];

    initial begin
        i_reset = 1'b0; i_tick = 1'b0; i_cmd_valid = 1'b0; i_cmd = 3'd0; i_cmd_arg = 2'd0;
        #12;
        check_all(0, mk(0,0,0,0, 4'h0, 0, 0, 0, 1, 0));
        @(negedge clock);
        i_reset = 1'b1;

        //            vld cmd arg tk  led  step cyc en rdy rate
        tbl.push_back(mk(1, 1, 0, 0, 4'h8, 0, 0, 0, 0, 0));   // RUN_SR -> LOAD
        tbl.push_back(mk(0, 0, 0, 0, 4'h8, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'h4, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'h2, 2, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'h1, 3, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'h8, 4, 1, 1, 1, 0));   // back to seed
        tbl.push_back(mk(0, 0, 0, 1, 4'h4, 5, 0, 1, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 4'hF, 0, 0, 0, 0, 0));   // RUN_FLASH from RUN
        tbl.push_back(mk(0, 0, 0, 0, 4'hF, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'h0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'hF, 2, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'h0, 3, 0, 1, 1, 0));
        tbl.push_back(mk(1, 4, 0, 0, 4'h0, 3, 0, 0, 1, 0));   // PAUSE
        tbl.push_back(mk(0, 0, 0, 1, 4'h0, 3, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'h0, 3, 0, 0, 1, 0));
        tbl.push_back(mk(1, 5, 0, 0, 4'h0, 3, 0, 1, 1, 0));   // RESUME
        tbl.push_back(mk(0, 0, 0, 1, 4'hF, 4, 1, 1, 1, 0));
        tbl.push_back(mk(1, 2, 0, 0, 4'h1, 0, 0, 0, 0, 0));   // RUN_SL
        tbl.push_back(mk(0, 0, 0, 0, 4'h1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'h2, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'h8, 0, 0, 0, 0, 0));   // RUN_SR + tick: tick dropped
        tbl.push_back(mk(1, 0, 0, 0, 4'h8, 0, 0, 1, 1, 0));   // STOP during LOAD not taken
        tbl.push_back(mk(0, 0, 0, 1, 4'h4, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 6, 2, 1, 4'h2, 2, 0, 1, 1, 2));   // SET_RATE + tick
        tbl.push_back(mk(1, 0, 0, 1, 4'h0,-1, 0, 0, 1, 2));   // STOP + tick
        tbl.push_back(mk(0, 0, 0, 1, 4'h0,-1, 0, 0, 1, 2));
        tbl.push_back(mk(1, 5, 0, 0, 4'h0,-1, 0, 0, 1, 2));   // RESUME in IDLE
        tbl.push_back(mk(1, 4, 0, 0, 4'h0,-1, 0, 0, 1, 2));   // PAUSE in IDLE
        tbl.push_back(mk(1, 6, 3, 0, 4'h0,-1, 0, 0, 1, 3));   // SET_RATE in IDLE
        tbl.push_back(mk(1, 1, 0, 0, 4'h8, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 4'h8, 0, 0, 1, 1, 3));
        tbl.push_back(mk(1, 5, 0, 1, 4'h4, 1, 0, 1, 1, 3));   // RESUME in RUN ignored, tick applies
        tbl.push_back(mk(1, 4, 0, 0, 4'h4, 1, 0, 0, 1, 3));
        tbl.push_back(mk(1, 3, 0, 0, 4'h4, 1, 0, 0, 1, 3));   // RUN_* in PAUSE ignored
        tbl.push_back(mk(1, 0, 0, 0, 4'h0,-1, 0, 0, 1, 3));   // STOP from PAUSE
        tbl.push_back(mk(1, 1, 0, 0, 4'h8, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 4'h8, 0, 0, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0, 1, 4'h4, 1, 0, 1, 1, 3));

        for (int i = 0; i < tbl.size(); i++) apply(i + 1, tbl[i]);

        // Asynchronous reset between edges while running.
        #3;
        i_reset = 1'b0;
        #1;
        check_all(100, mk(0,0,0,0, 4'h0, 0, 0, 0, 1, 0));
        i_tick = 1'b1;
        @(posedge clock);
        #1;
        check_all(101, mk(0,0,0,0, 4'h0, 0, 0, 0, 1, 0));
        @(negedge clock);
        i_reset = 1'b1;
        apply(102, mk(0, 0, 0, 1, 4'h0, 0, 0, 0, 1, 0));
        apply(103, mk(0, 0, 0, 1, 4'h0, 0, 0, 0, 1, 0));
        apply(104, mk(1, 1, 0, 0, 4'h8, 0, 0, 0, 0, 0));
        apply(105, mk(0, 0, 0, 1, 4'h8, 0, 0, 1, 1, 0));
        apply(106, mk(1, 0, 0, 0, 4'h0,-1, 0, 0, 1, 0));

`ifdef LED_SEQ_PINGPONG_EN
        apply(200, mk(1, 7, 0, 0, 4'h1, 0, 0, 0, 0, 0));
        apply(201, mk(0, 0, 0, 0, 4'h1, 0, 0, 1, 1, 0));
        apply(202, mk(0, 0, 0, 1, 4'h2, 1, 0, 1, 1, 0));
        apply(203, mk(0, 0, 0, 1, 4'h4, 2, 0, 1, 1, 0));
        apply(204, mk(0, 0, 0, 1, 4'h8, 3, 0, 1, 1, 0));
        apply(205, mk(0, 0, 0, 1, 4'h4, 4, 0, 1, 1, 0));
        apply(206, mk(0, 0, 0, 1, 4'h2, 5, 0, 1, 1, 0));
        apply(207, mk(0, 0, 0, 1, 4'h1, 6, 1, 1, 1, 0));
        apply(208, mk(0, 0, 0, 1, 4'h2, 7, 0, 1, 1, 0));
`else
        apply(200, mk(1, 7, 0, 0, 4'h0,-1, 0, 0, 1, 0));   // opcode 7 ignored in IDLE
        apply(201, mk(0, 0, 0, 1, 4'h0,-1, 0, 0, 1, 0));
`endif

        @(negedge clock);
        i_cmd_valid = 1'b0;
        i_tick      = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Command-driven sequencer for the tick counter and the LED pattern datapath.
- Configures the counter's rate select and enable, and consumes its one-cycle tick pulse.
- Advances an LED pattern per tick: shift-right, shift-left, or flash.
- Sits between the switch/button front-end (command source) and the counter/LED outputs.

Parameters:
- NB_LEDS, 4, LED pattern width (>=2).
- NB_RATE, 2, width of counter rate select.
- NB_STEP, 8, width of the tick-step counter.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_tick  in  1  one-cycle pulse from the counter.
- i_cmd_valid  in  1  command strobe.
- i_cmd  in  3  opcode.
- i_cmd_arg  in  NB_RATE  rate argument for SET_RATE.
- o_cmd_ready  out  1  command accepted when valid&ready.
- o_cnt_en  out  1  counter enable.
- o_rate  out  NB_RATE  counter rate select.
- o_led  out  NB_LEDS  LED pattern.
- o_step  out  NB_STEP  ticks consumed since last LOAD.
- o_cycle  out  1  one-cycle pulse when the pattern returns to its seed.

Behaviour:
- Reset (i_reset=0, asynchronous, effective mid-operation):
  - state=IDLE, mode=SR, rate=0.
  - o_led=0, o_step=0, o_cycle=0, o_cnt_en=0, o_cmd_ready=1.
- Opcodes:
  - 0 STOP, 1 RUN_SR, 2 RUN_SL, 3 RUN_FLASH.
  - 4 PAUSE, 5 RESUME, 6 SET_RATE, 7 reserved (see Optional Feature).
  - An accepted opcode that is not legal in the current state is consumed with no effect.
- States:
  - IDLE: o_led=0, cnt_en=0, ready=1. RUN_* stores mode -> LOAD.
  - LOAD (exactly 1 cycle): ready=0, cnt_en=0.
    - Seed: SR=MSB one-hot, SL=LSB one-hot, FLASH=all ones.
    - o_step=0. Next state RUN.
  - RUN: cnt_en=1, ready=1. On i_tick:
    - SR rotates right, SL rotates left, FLASH inverts.
    - o_step+1, wraps at 2^NB_STEP.
  - PAUSE: cnt_en=0; o_led and o_step held; RESUME -> RUN; STOP -> IDLE.
- Transitions from RUN:
  - PAUSE -> PAUSE.
  - STOP -> IDLE.
  - RUN_* (any mode, including the same one) -> LOAD, restarting from the seed.
- SET_RATE: legal in every state; o_rate <= i_cmd_arg, visible the cycle after acceptance; state unchanged.
- o_cycle: asserted the cycle after the tick that makes o_led equal the mode's seed.
  - SR/SL: every NB_LEDS ticks.
  - FLASH: every 2 ticks.
- Latency: tick at edge N -> o_led updated after edge N.
- Simultaneous tick and command in RUN:
  - STOP, PAUSE or RUN_*: the command wins and the tick is dropped (pattern and o_step unchanged).
  - SET_RATE: tick applied and rate updated in the same cycle.
- Ticks in IDLE, LOAD or PAUSE are ignored.
- Commands presented while ready=0 (LOAD) are not accepted; the source must hold valid.

Optional Feature:
- Macro: LED_SEQ_PINGPONG_EN.
- Defined: opcode 7 RUN_PP -> LOAD with seed = LSB one-hot, direction=left.
  - In RUN, each tick shifts in the current direction (non-rotating).
  - The direction reverses at bit NB_LEDS-1 and at bit 0, so the ends are not repeated.
  - o_cycle pulses when the pattern returns to the LSB, every 2*(NB_LEDS-1) ticks.
- Undefined: opcode 7 is consumed with no effect; no direction register is built.

Test Plan:
- Reset then RUN_SR with NB_LEDS=4, 5 ticks -> 1000, then 0100,0010,0001,1000,0100 after each tick; o_cycle pulses after tick 4; o_step=5.
- RUN_FLASH, 3 ticks, then PAUSE, 2 ticks, then RESUME, 1 tick -> 1111,0000,1111,0000 held through pause, then 1111; o_step=4; cnt_en low during PAUSE.
- In RUN_SL, assert RUN_SR and i_tick in the same cycle -> tick dropped; LOAD cycle with ready=0; o_led=1000; o_step=0.
- SET_RATE arg=2 together with a tick in RUN -> o_rate=2 next cycle and the pattern advances once; SET_RATE arg=3 in IDLE -> o_rate=3, state IDLE.
- Drive i_reset low asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately and rate=0; after release, ticks are ignored until a RUN_* command.
- With LED_SEQ_PINGPONG_EN, RUN_PP, 6 ticks -> 0001,0010,0100,1000,0100,0010,0001; o_cycle after tick 6. Without the macro, opcode 7 leaves the state at IDLE.
